n64_controller_tx: RTL

Controller-side transmitter for the N64 one-wire joybus. It serialises a response frame back to the console: info, button status, read data, or the write-ack CRC. Bytes are fetched from an upstream byte source and driven onto the open-drain line with N64 bit timing, followed by a controller stop bit. It runs after the receiver decodes a command, and its tx_active output gates the receiver's cur_operation.

---
 rtl/n64_pkg.sv | 45 ++++
 rtl/n64_tx_bit_timer.sv | 44 ++++
 rtl/n64_controller_tx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/n64_pkg.sv
// Shared definitions for the N64 joybus controller transmitter: line timing
// in microseconds, the transmit FSM state type and the pak-data CRC-8 helpers.
package n64_pkg;

  localparam int BIT_US      = 4;
  localparam int SHORT_US    = 1;
  localparam int LONG_US     = 3;
  localparam int STOP_LOW_US = 2;
  localparam int GUARD_US    = 2;

  localparam logic [7:0] CRC_POLY = 8'h85;

  // Wide enough for the longest single phase (3 us)
  localparam int US_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_STOP_LOW,
    ST_GUARD
  } tx_state_t;

  // Low time of a data bit: a '1' is a short pulse, a '0' a long one
  function automatic logic [US_W-1:0] bit_low_us(input logic b);
    return b ? US_W'(SHORT_US) : US_W'(LONG_US);
  endfunction

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic [7:0] nxt;
    nxt = {crc[6:0], din};
    if (crc[7]) nxt = nxt ^ CRC_POLY;
    return nxt;
  endfunction

  // The pak CRC is defined over the data followed by eight zero bits
  function automatic logic [7:0] crc8_flush(input logic [7:0] crc);
    logic [7:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) c = crc8_step(c, 1'b0);
    return c;
  endfunction

endpackage

// File: rtl/n64_tx_bit_timer.sv
// Phase timer for the joybus transmitter: a 1 us prescaler plus a microsecond
// counter; phase_done marks the last cycle of a phase of phase_us microseconds.
module n64_tx_bit_timer
  import n64_pkg::*;
#(
  parameter int CLKS_PER_US = 50
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic [US_W-1:0] phase_us,
  output logic            phase_done,
  output logic            phase_near
);

  localparam int PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

  logic [PRE_W-1:0] pre;
  logic [US_W-1:0]  us_cnt;
  logic             pre_wrap;
  logic             last_us;

  assign pre_wrap   = (pre == PRE_W'(CLKS_PER_US - 1));
  assign last_us    = (us_cnt == (phase_us - US_W'(1)));
  assign phase_done = pre_wrap && last_us;
  // One cycle ahead of phase_done so callers can register a last-cycle output
  assign phase_near = (pre == PRE_W'(CLKS_PER_US - 2)) && last_us;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre    <= '0;
      us_cnt <= '0;
    end else if (load) begin
      pre    <= '0;
      us_cnt <= '0;
    end else if (pre_wrap) begin
      pre    <= '0;
      us_cnt <= us_cnt + US_W'(1);
    end else begin
      pre    <= pre + PRE_W'(1);
    end
  end

endmodule

// File: rtl/n64_controller_tx.sv
// N64 joybus controller-side transmitter: fetches payload bytes, drives them
// MSB first with joybus bit timing, then a stop bit and a released guard time.
// Define N64_TX_CRC_EN to append the pak-data CRC-8 byte after the payload.
module n64_controller_tx
  import n64_pkg::*;
#(
  parameter int CLKS_PER_US = 50,
  parameter int LEN_W       = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             byte_rd,
  output logic [LEN_W-1:0] byte_addr,
  input  logic [7:0]       byte_in,
  output logic             drive_low,
  output logic             tx_active,
  output logic             done
);

  tx_state_t        state;
  logic [7:0]       shift;
  logic [7:0]       prefetch;
  logic [2:0]       bit_idx;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] addr_q;
  logic             rd_q;
  logic             capture_q;
  logic             have_next;
  logic [US_W-1:0]  phase_us;
  logic             phase_done;
  logic             phase_near;
  logic             timer_load;
  logic             accept;
  logic             more_bytes;

`ifdef N64_TX_CRC_EN
  logic [7:0] crc;
  logic [7:0] crc_final;
  logic       crc_phase;

  assign crc_final = crc8_flush(crc);
`endif

  assign accept     = (state == ST_IDLE) && start && (len != '0);
  assign more_bytes = ({1'b0, addr_q} + (LEN_W+1)'(1)) < {1'b0, len_q};

  // The first read goes out in the start cycle so byte 0 is on byte_in during FETCH
  assign byte_rd   = rd_q | accept;
  assign byte_addr = accept ? '0 : addr_q;

  // Counters sit at zero outside timed states and restart on every phase change
  assign timer_load = (state == ST_IDLE) || (state == ST_FETCH) || phase_done;

  n64_tx_bit_timer #(
    .CLKS_PER_US (CLKS_PER_US)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .phase_us   (phase_us),
    .phase_done (phase_done),
    .phase_near (phase_near)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      shift     <= '0;
      prefetch  <= '0;
      bit_idx   <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      capture_q <= 1'b0;
      have_next <= 1'b0;
      phase_us  <= '0;
      drive_low <= 1'b0;
      tx_active <= 1'b0;
      done      <= 1'b0;
`ifdef N64_TX_CRC_EN
      crc       <= '0;
      crc_phase <= 1'b0;
`endif
    end else begin
      rd_q      <= 1'b0;
      done      <= 1'b0;
      capture_q <= rd_q;
      if (capture_q) prefetch <= byte_in;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            len_q     <= len;
            addr_q    <= '0;
            have_next <= 1'b0;
            tx_active <= 1'b1;
`ifdef N64_TX_CRC_EN
            crc       <= '0;
            crc_phase <= 1'b0;
`endif
            state     <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          shift     <= byte_in;
          bit_idx   <= 3'd7;
          drive_low <= 1'b1;
          phase_us  <= bit_low_us(byte_in[7]);
`ifdef N64_TX_CRC_EN
          crc       <= crc8_step(crc, byte_in[7]);
`endif
          state     <= ST_BIT_LOW;
        end

        ST_BIT_LOW: begin
          if (phase_done) begin
            drive_low <= 1'b0;
            phase_us  <= US_W'(BIT_US) - bit_low_us(shift[7]);
            state     <= ST_BIT_HIGH;
          end
        end

        ST_BIT_HIGH: begin
          if (phase_done) begin
            if (bit_idx != 3'd0) begin
              shift     <= {shift[6:0], 1'b0};
              bit_idx   <= bit_idx - 3'd1;
              drive_low <= 1'b1;
              phase_us  <= bit_low_us(shift[6]);
              state     <= ST_BIT_LOW;
`ifdef N64_TX_CRC_EN
              if (!crc_phase) crc <= crc8_step(crc, shift[6]);
              // Entering the last bit of a payload byte: prefetch the next one
              if ((bit_idx == 3'd1) && more_bytes && !crc_phase) begin
`else
              if ((bit_idx == 3'd1) && more_bytes) begin
`endif
                rd_q      <= 1'b1;
                addr_q    <= addr_q + LEN_W'(1);
                have_next <= 1'b1;
              end
            end else if (have_next) begin
              shift     <= prefetch;
              bit_idx   <= 3'd7;
              have_next <= 1'b0;
              drive_low <= 1'b1;
              phase_us  <= bit_low_us(prefetch[7]);
              state     <= ST_BIT_LOW;
`ifdef N64_TX_CRC_EN
              crc       <= crc8_step(crc, prefetch[7]);
`endif
            end
`ifdef N64_TX_CRC_EN
            else if (!crc_phase) begin
              shift     <= crc_final;
              bit_idx   <= 3'd7;
              crc_phase <= 1'b1;
              drive_low <= 1'b1;
              phase_us  <= bit_low_us(crc_final[7]);
              state     <= ST_BIT_LOW;
            end
`endif
            else begin
              drive_low <= 1'b1;
              phase_us  <= US_W'(STOP_LOW_US);
              state     <= ST_STOP_LOW;
            end
          end
        end

        ST_STOP_LOW: begin
          if (phase_done) begin
            drive_low <= 1'b0;
            phase_us  <= US_W'(GUARD_US);
            state     <= ST_GUARD;
          end
        end

        ST_GUARD: begin
          // done and the tx_active drop both land on the final guard cycle
          if (phase_near) begin
            done      <= 1'b1;
            tx_active <= 1'b0;
          end
          if (phase_done) state <= ST_IDLE;
        end

        default: begin
          drive_low <= 1'b0;
          tx_active <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
